// File: rtl/alu_sequencer.sv
// Small program sequencer feeding one instruction per cycle to an external accumulator ALU.
// Captures the ALU result each RUN cycle and aborts on a divide-by-zero instruction.
module alu_sequencer #(
    parameter int         PROG_DEPTH = 16,
    parameter logic [3:0] NOP_OP     = 4'b0000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       start,
    input  logic [4:0] len,
    input  logic [3:0] C,
    output logic [3:0] opcode,
    output logic [3:0] A,
    output logic [3:0] pc,
    output logic       busy,
    output logic       done,
    output logic [3:0] result,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [3:0] DIV_OP = 4'b0100;
    localparam logic [4:0] DEPTH5 = 5'(PROG_DEPTH);
    localparam logic [4:0] MAX_LEN = 5'd16;

    state_t     state_reg;
    logic [4:0] count_reg;
    logic [7:0] mem [PROG_DEPTH];

    logic [7:0] instr;
    logic       div_zero;
    logic       issue;
    logic       wr_ok;

    assign instr    = mem[pc];
    assign div_zero = (state_reg == RUN) && (instr[7:4] == DIV_OP) && (instr[3:0] == 4'd0);
    assign issue    = (state_reg == RUN) && !div_zero;
    assign opcode   = issue ? instr[7:4] : NOP_OP;
    assign A        = issue ? instr[3:0] : 4'd0;
    assign wr_ok    = wr_en && (state_reg != RUN) && ({1'b0, wr_addr} < DEPTH5);

    // Program memory is cleared by reset, so it lives in registers rather than block RAM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < PROG_DEPTH; i++) begin
                mem[i] <= {NOP_OP, 4'b0000};
            end
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            pc        <= 4'd0;
            count_reg <= 5'd0;
            result    <= 4'd0;
            err       <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        err <= 1'b0;
                        if (len == 5'd0) begin
                            state_reg <= DONE;
                            done      <= 1'b1;
                        end else begin
                            state_reg <= RUN;
                            busy      <= 1'b1;
                            pc        <= 4'd0;
                            count_reg <= (len > MAX_LEN) ? MAX_LEN : len;
                        end
                    end
                end
                RUN: begin
                    if (div_zero) begin
                        err       <= 1'b1;
                        state_reg <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        result    <= C;
                        pc        <= pc + 4'd1;
                        count_reg <= count_reg - 5'd1;
                        if (count_reg == 5'd1) begin
                            state_reg <= DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with an accumulator ALU model attached;
// expected issues are queued before each run and compared as the DUT issues them.
module tb_alu_sequencer;

    localparam logic [3:0] NOP = 4'b0000;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       start;
    logic [4:0] len;
    logic [3:0] alu_c;
    logic [3:0] opcode;
    logic [3:0] A;
    logic [3:0] pc;
    logic       busy;
    logic       done;
    logic [3:0] result;
    logic       err;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] a;
        logic [3:0] pc;
    } issue_t;

    issue_t sb [$];

    alu_sequencer #(.PROG_DEPTH(16), .NOP_OP(NOP)) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .start   (start),
        .len     (len),
        .C       (alu_c),
        .opcode  (opcode),
        .A       (A),
        .pc      (pc),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .err     (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Accumulator ALU: E=LOAD, 3=MUL, 4=DIV, anything else passes the accumulator through.
    logic [3:0] acc;
    logic [7:0] prod;
    assign prod = {4'b0, acc} * {4'b0, A};

    always_comb begin
        case (opcode)
            4'hE:    alu_c = A;
            4'h3:    alu_c = prod[3:0];
            4'h4:    alu_c = (A != 4'd0) ? acc / A : acc;
            default: alu_c = acc;
        endcase
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) acc <= 4'd0;
        else if (opcode != NOP) acc <= alu_c;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every RUN cycle must match the next queued issue; outside RUN the ALU sees NOP/0.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (busy) begin
                checks++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_issue: observed pc=%0d op=%h A=%h expected none", pc, opcode, A);
                end
                if (sb.size() != 0) begin
                    issue_t e;
                    e = sb.pop_front();
                    check("issue_op", opcode, e.op);
                    check("issue_a", A, e.a);
                    check("issue_pc", pc, e.pc);
                    $display("issue pc=%0d opcode=%h A=%h C=%h", pc, opcode, A, alu_c);
                end
            end else begin
                check("idle_opcode", opcode, NOP);
                check("idle_a", A, 4'd0);
            end
        end
    end

    task automatic write_mem(input logic [3:0] addr, input logic [7:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic push(input logic [3:0] op, input logic [3:0] a, input logic [3:0] p);
        issue_t e;
        e.op = op;
        e.a  = a;
        e.pc = p;
        sb.push_back(e);
    endtask

    // Edge count includes the start edge itself; wr_busy hammers mem1 with FF while the run is active.
    task automatic run_prog(input string tag, input logic [4:0] l, input int exp_edges,
                            input logic [3:0] exp_res, input logic exp_err, input logic wr_busy);
        int edges;
        start = 1'b1;
        len   = l;
        @(posedge clk);
        #1;
        start = 1'b0;
        edges = 1;
        if (wr_busy) begin
            wr_en   = 1'b1;
            wr_addr = 4'd1;
            wr_data = 8'hFF;
        end
        while (!done && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        wr_en = 1'b0;
        $display("run %s: len=%0d edges=%0d result=%h err=%0b", tag, l, edges, result, err);
        check({tag, "_latency"}, edges, exp_edges);
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_result"}, result, exp_res);
        check({tag, "_err"}, err, exp_err);
        check({tag, "_pending"}, sb.size(), 0);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, done, 1'b0);
        check({tag, "_err_hold"}, err, exp_err);
    endtask

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_addr = 4'd0;
        wr_data = 8'd0;
        start   = 1'b0;
        len     = 5'd0;
        #3 rst = 1'b0;
        #1;
        check("rst_opcode", opcode, NOP);
        check("rst_a", A, 4'd0);
        check("rst_pc", pc, 4'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_result", result, 4'd0);
        check("rst_err", err, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        // LOAD 5, MUL 3, DIV 2 -> 7
        write_mem(4'd0, 8'hE5);
        write_mem(4'd1, 8'h33);
        write_mem(4'd2, 8'h42);
        push(4'hE, 4'd5, 4'd0);
        push(4'h3, 4'd3, 4'd1);
        push(4'h4, 4'd2, 4'd2);
        run_prog("basic", 5'd3, 4, 4'd7, 1'b0, 1'b0);

        // Divide by zero aborts in the second cycle; mem2 is never issued
        write_mem(4'd1, 8'h40);
        write_mem(4'd2, 8'h33);
        push(4'hE, 4'd5, 4'd0);
        push(NOP, 4'd0, 4'd1);
        run_prog("divzero", 5'd3, 3, 4'd5, 1'b1, 1'b0);

        // len=0 completes at once, clears err and leaves result alone
        run_prog("len0", 5'd0, 1, 4'd5, 1'b0, 1'b0);

        // Writes during a run are dropped, so the rerun matches
        write_mem(4'd1, 8'h33);
        write_mem(4'd2, 8'h42);
        push(4'hE, 4'd5, 4'd0);
        push(4'h3, 4'd3, 4'd1);
        push(4'h4, 4'd2, 4'd2);
        run_prog("busywr", 5'd3, 4, 4'd7, 1'b0, 1'b1);
        push(4'hE, 4'd5, 4'd0);
        push(4'h3, 4'd3, 4'd1);
        push(4'h4, 4'd2, 4'd2);
        run_prog("rerun", 5'd3, 4, 4'd7, 1'b0, 1'b0);

        // Reset in the second RUN cycle
        push(4'hE, 4'd5, 4'd0);
        push(4'h3, 4'd3, 4'd1);
        push(4'h4, 4'd2, 4'd2);
        start = 1'b1;
        len   = 5'd3;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("midrst_opcode", opcode, NOP);
        check("midrst_a", A, 4'd0);
        check("midrst_pc", pc, 4'd0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_result", result, 4'd0);
        check("midrst_err", err, 1'b0);
        sb.delete();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("postrst_done", done, 1'b0);
            check("postrst_busy", busy, 1'b0);
        end
        push(NOP, 4'd0, 4'd0);
        push(NOP, 4'd0, 4'd1);
        run_prog("nopmem", 5'd2, 3, 4'd0, 1'b0, 1'b0);
        write_mem(4'd0, 8'hE5);
        write_mem(4'd1, 8'h33);
        write_mem(4'd2, 8'h42);
        push(4'hE, 4'd5, 4'd0);
        push(4'h3, 4'd3, 4'd1);
        push(4'h4, 4'd2, 4'd2);
        run_prog("reload", 5'd3, 4, 4'd7, 1'b0, 1'b0);

        // Full-depth program, then an oversize len clamped to 16
        for (int i = 0; i < 16; i++) write_mem(4'(i), 8'hE1);
        for (int i = 0; i < 16; i++) push(4'hE, 4'd1, 4'(i));
        run_prog("len16", 5'd16, 17, 4'd1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) push(4'hE, 4'd1, 4'(i));
        run_prog("len20", 5'd20, 17, 4'd1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
